// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcode map, ALU operation codes and the control-strobe bundle.
package mcu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    WAIT_WB = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Opcode map; anything at or above OPC_JUMP + 1 traps as illegal.
  localparam int OPC_LOAD  = 0;
  localparam int OPC_STORE = 1;
  localparam int OPC_ADD   = 2;
  localparam int OPC_SUB   = 3;
  localparam int OPC_INV   = 4;
  localparam int OPC_SLL   = 5;
  localparam int OPC_SRL   = 6;
  localparam int OPC_AND   = 7;
  localparam int OPC_OR    = 8;
  localparam int OPC_SLT   = 9;
  localparam int OPC_BEQ   = 10;
  localparam int OPC_BNE   = 11;
  localparam int OPC_JUMP  = 12;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_INV = 2;
  localparam int ALU_SLL = 3;
  localparam int ALU_SRL = 4;
  localparam int ALU_AND = 5;
  localparam int ALU_OR  = 6;
  localparam int ALU_SLT = 7;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic write_back;
    logic alu_mode;
    logic execute;
    logic jump_execute;
  } strobe_t;

  // ALU operation selected by an ALU-class opcode.
  function automatic int alu_sel(input int opc);
    case (opc)
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_INV: return ALU_INV;
      OPC_SLL: return ALU_SLL;
      OPC_SRL: return ALU_SRL;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      default: return ALU_SLT;
    endcase
  endfunction

endpackage

// File: rtl/mcu_opcode_decoder.sv
// Combinational opcode decoder: maps an opcode to its control-strobe bundle,
// ALU operation and an illegal-opcode flag. No state; the caller registers.
module mcu_opcode_decoder
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output strobe_t             strobes,
  output logic [ALU_OP_W-1:0] op,
  output logic                illegal
);

  int opc_i;
  assign opc_i = int'(opcode);

  // Decode one opcode into strobes, ALU select and the illegal flag.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    strobes = '0;
    op      = '0;
    illegal = 1'b0;
    case (opc_i)
      OPC_LOAD: begin
        strobes.mem_read   = 1'b1;
        strobes.write_back = 1'b1;
        strobes.execute    = 1'b1;
        op                 = ALU_OP_W'(ALU_ADD);
      end
      OPC_STORE: begin
        strobes.mem_write = 1'b1;
        strobes.execute   = 1'b1;
        op                = ALU_OP_W'(ALU_ADD);
      end
      OPC_ADD, OPC_SUB, OPC_INV, OPC_SLL, OPC_SRL, OPC_AND, OPC_OR, OPC_SLT: begin
        strobes.alu_mode   = 1'b1;
        strobes.write_back = 1'b1;
        strobes.execute    = 1'b1;
        op                 = ALU_OP_W'(alu_sel(opc_i));
      end
      OPC_BEQ: begin
        strobes.execute = 1'b1;
        op              = ALU_OP_W'(ALU_SUB);
      end
      OPC_BNE: begin
        strobes.execute = 1'b1;
        op              = ALU_OP_W'(ALU_INV);
      end
      OPC_JUMP: begin
        strobes.jump_execute = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH -> EXECUTE -> WAIT_WB -> RECOVER.
// All outputs are registered; strobes appear the cycle after the opcode is
// accepted. Optional MCU_PERF_COUNTERS_EN adds retired/trap counters.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int ALU_OP_W   = 3,
  parameter int WB_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                decode_complete,
  input  logic                writeback_complete,
  output logic                read_instruction,
  output logic                mem_read,
  output logic                mem_write,
  output logic                write_back,
  output logic                alu_mode,
  output logic [ALU_OP_W-1:0] op,
  output logic                execute,
  output logic                jump_execute,
  output logic                reset_instruction_memory,
  output logic                reset_alu,
  output logic                reset_data_memory,
  output logic                illegal_opcode,
  output logic                wb_timeout,
`ifdef MCU_PERF_COUNTERS_EN
  output logic [15:0]         retired_count,
  output logic [7:0]          trap_count,
`endif
  output logic                busy
);

  localparam int CNT_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

  state_t              state;
  logic [OPCODE_W-1:0] opcode_q;
  logic [OPCODE_W-1:0] dec_opcode;
  strobe_t             dec_strobes;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_illegal;
  strobe_t             strb;
  logic [CNT_W-1:0]    wb_cnt;
  logic                wb_done;
  logic                timeout_hit;

  // Decode the live opcode while fetching, the latched one afterwards.
  assign dec_opcode = (state == FETCH) ? opcode : opcode_q;

  mcu_opcode_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decoder (
    .opcode  (dec_opcode),
    .strobes (dec_strobes),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // Writeback completion takes priority over a coincident timeout.
  assign wb_done     = (state == WAIT_WB) && writeback_complete;
  assign timeout_hit = (state == WAIT_WB) && !writeback_complete && (wb_cnt == CNT_LAST);

  assign mem_read     = strb.mem_read;
  assign mem_write    = strb.mem_write;
  assign write_back   = strb.write_back;
  assign alu_mode     = strb.alu_mode;
  assign execute      = strb.execute;
  assign jump_execute = strb.jump_execute;

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= FETCH;
      opcode_q                 <= '0;
      wb_cnt                   <= '0;
      strb                     <= '0;
      op                       <= '0;
      read_instruction         <= 1'b1;
      reset_instruction_memory <= 1'b0;
      reset_alu                <= 1'b0;
      reset_data_memory        <= 1'b0;
      illegal_opcode           <= 1'b0;
      wb_timeout               <= 1'b0;
      busy                     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      illegal_opcode <= 1'b0;
      wb_timeout     <= 1'b0;
      case (state)
        FETCH: begin
          if (decode_complete) begin
            state                    <= EXECUTE;
            opcode_q                 <= opcode;
            strb                     <= dec_strobes;
            op                       <= dec_op;
            illegal_opcode           <= dec_illegal;
            read_instruction         <= 1'b0;
            reset_instruction_memory <= 1'b1;
            busy                     <= 1'b1;
          end
        end
        EXECUTE: begin
          if (dec_strobes.jump_execute || dec_illegal) begin
            state                    <= RECOVER;
            strb                     <= '0;
            op                       <= '0;
            reset_instruction_memory <= 1'b0;
            reset_alu                <= 1'b1;
            reset_data_memory        <= 1'b1;
          end else begin
            state <= WAIT_WB;
          end
        end
        WAIT_WB: begin
          if (wb_done || timeout_hit) begin
            state                    <= RECOVER;
            strb                     <= '0;
            op                       <= '0;
            reset_instruction_memory <= 1'b0;
            reset_alu                <= 1'b1;
            reset_data_memory        <= 1'b1;
            wb_timeout               <= timeout_hit;
          end else begin
            wb_cnt <= wb_cnt + 1'b1;
          end
        end
        default: begin // RECOVER
          state             <= FETCH;
          wb_cnt            <= '0;
          reset_alu         <= 1'b0;
          reset_data_memory <= 1'b0;
          read_instruction  <= 1'b1;
          busy              <= 1'b0;
        end
      endcase
    end
  end

`ifdef MCU_PERF_COUNTERS_EN
  logic retire_evt;
  logic trap_evt;

  assign retire_evt = ((state == EXECUTE) && dec_strobes.jump_execute) || wb_done;
  assign trap_evt   = ((state == FETCH) && decode_complete && dec_illegal) || timeout_hit;

  // Retired count wraps; trap count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
      trap_count    <= '0;
    end else begin
      if (retire_evt) retired_count <= retired_count + 16'd1;
      if (trap_evt && (trap_count != 8'hFF)) trap_count <= trap_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (WB_TIMEOUT = 4).
// Output vector layout: {read_instruction, mem_read, mem_write, write_back,
// alu_mode, op[2:0], execute, jump_execute, reset_instruction_memory,
// reset_alu, reset_data_memory, illegal_opcode, wb_timeout, busy}.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic       decode_complete = 1'b0;
  logic       writeback_complete = 1'b0;
  logic       read_instruction, mem_read, mem_write, write_back, alu_mode;
  logic [2:0] op;
  logic       execute, jump_execute, reset_instruction_memory, reset_alu;
  logic       reset_data_memory, illegal_opcode, wb_timeout, busy;
`ifdef MCU_PERF_COUNTERS_EN
  logic [15:0] retired_count;
  logic [7:0]  trap_count;
`endif

  multicycle_control_unit #(
    .OPCODE_W   (4),
    .ALU_OP_W   (3),
    .WB_TIMEOUT (4)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .opcode                   (opcode),
    .decode_complete          (decode_complete),
    .writeback_complete       (writeback_complete),
    .read_instruction         (read_instruction),
    .mem_read                 (mem_read),
    .mem_write                (mem_write),
    .write_back               (write_back),
    .alu_mode                 (alu_mode),
    .op                       (op),
    .execute                  (execute),
    .jump_execute             (jump_execute),
    .reset_instruction_memory (reset_instruction_memory),
    .reset_alu                (reset_alu),
    .reset_data_memory        (reset_data_memory),
    .illegal_opcode           (illegal_opcode),
    .wb_timeout               (wb_timeout),
`ifdef MCU_PERF_COUNTERS_EN
    .retired_count            (retired_count),
    .trap_count               (trap_count),
`endif
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] V_FETCH   = 16'h8000;
  localparam logic [15:0] V_RECOVER = 16'h0019;
  localparam logic [15:0] V_TIMEOUT = 16'h001B;

  typedef struct {
    int opc;
    int mr, mw, wb, alu, op, ex, jmp, ill;
  } vec_t;

  vec_t vt[16];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_retired = 0;
  int   exp_trap = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {read_instruction, mem_read, mem_write, write_back, alu_mode, op,
            execute, jump_execute, reset_instruction_memory, reset_alu,
            reset_data_memory, illegal_opcode, wb_timeout, busy};
  endfunction

  // Expected vector during EXECUTE (and held through WAIT_WB).
  function automatic logic [15:0] exp_exec(input vec_t v);
    return {1'b0, 1'(v.mr), 1'(v.mw), 1'(v.wb), 1'(v.alu), 3'(v.op),
            1'(v.ex), 1'(v.jmp), 1'b1, 1'b0, 1'b0, 1'(v.ill), 1'b0, 1'b1};
  endfunction

  task automatic accept(input logic [3:0] opc);
    opcode = opc;
    decode_complete = 1'b1;
    step();
    decode_complete = 1'b0;
    opcode = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, jc, pulses, pulse_at, fetch_at, ra_seen;
    //            opc mr mw wb alu op ex jmp ill
    vt[0]  = '{0,  1, 0, 1, 0, 0, 1, 0, 0};
    vt[1]  = '{1,  0, 1, 0, 0, 0, 1, 0, 0};
    vt[2]  = '{2,  0, 0, 1, 1, 0, 1, 0, 0};
    vt[3]  = '{3,  0, 0, 1, 1, 1, 1, 0, 0};
    vt[4]  = '{4,  0, 0, 1, 1, 2, 1, 0, 0};
    vt[5]  = '{5,  0, 0, 1, 1, 3, 1, 0, 0};
    vt[6]  = '{6,  0, 0, 1, 1, 4, 1, 0, 0};
    vt[7]  = '{7,  0, 0, 1, 1, 5, 1, 0, 0};
    vt[8]  = '{8,  0, 0, 1, 1, 6, 1, 0, 0};
    vt[9]  = '{9,  0, 0, 1, 1, 7, 1, 0, 0};
    vt[10] = '{10, 0, 0, 0, 0, 1, 1, 0, 0};
    vt[11] = '{11, 0, 0, 0, 0, 2, 1, 0, 0};
    vt[12] = '{12, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[13] = '{13, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[14] = '{14, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[15] = '{15, 0, 0, 0, 0, 0, 0, 0, 1};

    // Reset held, then released.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outs(), V_FETCH);
    rst_n = 1'b1;
    step();
    check("reset_release", outs(), V_FETCH);

    // Table sweep over every opcode.
    for (int i = 0; i < 16; i++) begin
      accept(4'(vt[i].opc));
      check($sformatf("exec_opc%0d", i), outs(), exp_exec(vt[i]));
      if (vt[i].jmp != 0 || vt[i].ill != 0) begin
        step();
        check($sformatf("recover_opc%0d", i), outs(), V_RECOVER);
      end else begin
        step();
        check($sformatf("wait_hold_opc%0d", i), outs(), exp_exec(vt[i]));
        writeback_complete = 1'b1;
        step();
        writeback_complete = 1'b0;
        check($sformatf("recover_opc%0d", i), outs(), V_RECOVER);
      end
      step();
      check($sformatf("fetch_opc%0d", i), outs(), V_FETCH);
      if (vt[i].ill != 0) exp_trap++;
      else exp_retired++;
    end

    // Add, writeback after a few WAIT_WB cycles.
    accept(4'd2);
    check("add_exec", outs(), exp_exec(vt[2]));
    step();
    check("add_wait1", outs(), exp_exec(vt[2]));
    step();
    check("add_wait2", outs(), exp_exec(vt[2]));
    writeback_complete = 1'b1;
    step();
    writeback_complete = 1'b0;
    check("add_recover", outs(), V_RECOVER);
    step();
    check("add_fetch", outs(), V_FETCH);
    exp_retired++;

    // Jump: one-cycle strobe, back in FETCH on the third sample.
    accept(4'd12);
    jc = 0;
    fetch_at = 0;
    for (c = 1; c <= 8; c++) begin
      if (jump_execute) jc++;
      if (read_instruction) begin
        fetch_at = c;
        break;
      end
      step();
    end
    check("jump_pulse_cycles", 16'(jc), 16'd1);
    check("jump_fetch_latency", 16'(fetch_at), 16'd3);
    exp_retired++;

    // Load with no writeback: timeout after 4 WAIT_WB cycles.
    accept(4'd0);
    pulses = 0;
    pulse_at = 0;
    fetch_at = 0;
    for (c = 1; c <= 12; c++) begin
      if (wb_timeout) begin
        pulses++;
        pulse_at = c;
        check("timeout_recover_vec", outs(), V_TIMEOUT);
      end
      if (read_instruction) begin
        fetch_at = c;
        break;
      end
      step();
    end
    check("timeout_pulses", 16'(pulses), 16'd1);
    check("timeout_pulse_at", 16'(pulse_at), 16'd6);
    check("timeout_fetch_at", 16'(fetch_at), 16'd7);
    exp_trap++;

    // Writeback arriving in the timeout cycle wins.
    accept(4'd0);
    repeat (4) step();
    check("race_wait4", outs(), exp_exec(vt[0]));
    writeback_complete = 1'b1;
    step();
    writeback_complete = 1'b0;
    check("race_recover_no_timeout", outs(), V_RECOVER);
    step();
    check("race_fetch", outs(), V_FETCH);
    exp_retired++;

    // Inputs ignored outside their states: writeback held through EXECUTE,
    // decode_complete with a different opcode held through the instruction.
    writeback_complete = 1'b1;
    opcode = 4'd0;
    decode_complete = 1'b1;
    step();
    opcode = 4'd12;
    check("ignore_exec", outs(), exp_exec(vt[0]));
    step();
    check("ignore_wait", outs(), exp_exec(vt[0]));
    step();
    check("ignore_recover", outs(), V_RECOVER);
    decode_complete = 1'b0;
    writeback_complete = 1'b0;
    opcode = 4'd0;
    step();
    check("ignore_fetch", outs(), V_FETCH);
    exp_retired++;

`ifdef MCU_PERF_COUNTERS_EN
    check("retired_count", retired_count, 16'(exp_retired));
    check("trap_count", 16'(trap_count), 16'(exp_trap));
`endif

    // Reset during WAIT_WB of a Store.
    accept(4'd1);
    step();
    check("store_wait_mem_write", 16'(mem_write), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs(), V_FETCH);
    ra_seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (reset_alu) ra_seen = 1;
    end
    rst_n = 1'b1;
    check("no_recover_on_reset", 16'(ra_seen), 16'd0);
    step();
    check("post_reset_fetch", outs(), V_FETCH);
`ifdef MCU_PERF_COUNTERS_EN
    check("retired_cleared", retired_count, 16'd0);
    check("trap_cleared", 16'(trap_count), 16'd0);
`endif
    accept(4'd0);
    check("post_reset_load_exec", outs(), exp_exec(vt[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
